// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-master RAM arbiter: FSM state encodings and master ids.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StGnt0 = ST_GNT0,
    StGnt1 = ST_GNT1
  } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational next-owner picker. Define ARB_RR_EN for round-robin tie-breaking;
// otherwise master 0 (CPU) always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic m0_valid,
  input  logic m1_valid,
  input  logic last_gnt,
  output logic any_req,
  output logic pick_id
);

  always_comb begin
    any_req = m0_valid | m1_valid;
    pick_id = M_CPU;
    if (m0_valid && m1_valid) begin
`ifdef ARB_RR_EN
      pick_id = ~last_gnt;
`else
      pick_id = M_CPU;
`endif
    end else if (m1_valid) begin
      pick_id = M_DMA;
    end
  end

`ifndef ARB_RR_EN
  // last_gnt is still tracked upstream but does not steer a fixed-priority pick.
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
`endif

endmodule

// File: rtl/mem_arbiter2.sv
// Two-master (CPU, AES DMA) arbiter in front of the RAM slave; one transaction per grant.
// Tie-breaking is round-robin when ARB_RR_EN is defined, fixed CPU priority otherwise.
module mem_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            m0_valid,
  output logic            m0_ready,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wstrb,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_valid,
  output logic            m1_ready,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  output logic [DW-1:0]   m1_rdata,
  output logic            s_valid,
  input  logic            s_ready,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wstrb,
  input  logic [DW-1:0]   s_rdata
);

  arb_state_e state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic       any_req, pick_id;

  mem_arb_pick u_pick (
    .m0_valid (m0_valid),
    .m1_valid (m1_valid),
    .last_gnt (last_gnt_q),
    .any_req  (any_req),
    .pick_id  (pick_id)
  );

  // A grant ends on the slave's completion or when the owner withdraws; every
  // grant passes back through idle, so the slave always sees a gap.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d    = (pick_id == M_DMA) ? StGnt1 : StGnt0;
          last_gnt_d = pick_id;
        end
      end
      StGnt0:  if (s_ready || !m0_valid) state_d = StIdle;
      StGnt1:  if (s_ready || !m1_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      last_gnt_q <= M_DMA;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Outputs are gated by rstn so a reset mid-transaction drops s_valid and
  // suppresses any ready in the same cycle.
  always_comb begin
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    if (rstn) begin
      unique case (state_q)
        StGnt0: begin
          s_valid  = m0_valid;
          s_addr   = m0_addr;
          s_wdata  = m0_wdata;
          s_wstrb  = m0_wstrb;
          m0_ready = s_ready;
        end
        StGnt1: begin
          s_valid  = m1_valid;
          s_addr   = m1_addr;
          s_wdata  = m1_wdata;
          s_wstrb  = m1_wstrb;
          m1_ready = s_ready;
        end
        default: ;
      endcase
    end
    m0_rdata = rstn ? s_rdata : '0;
    m1_rdata = rstn ? s_rdata : '0;
  end

endmodule
